hazard_unit: RTL and testbench

- Parametrised hazard and forwarding controller for the pipelined RV32I core; sits beside the decode stage.
- Replaces single-stage, combinational-only forwarding with a registered shadow pipeline of in-flight destinations.
- Provides multi-stage forwarding with youngest-wins priority, load-use stall insertion and a counted front-end flush after redirects.
- Decode supplies per-instruction register usage; the EX/MEM datapath consumes forward selects, stall, bubble and flush.

---
 rtl/hazard_unit_pkg.sv | 23 ++
 rtl/hazard_shadow_pipe.sv | 30 +++
 rtl/hazard_unit.sv | 104 ++++++++++
 tb/tb_hazard_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// rtl/hazard_unit_pkg.sv - shared types, constants and helpers for the hazard/forwarding controller
package hazard_unit_pkg;

    // Widest register address the shadow entries can hold; narrower REG_AW values are zero-extended.
    localparam int HZ_RD_W = 8;

    // Forward select value meaning "take the operand from the register file".
    localparam int FWD_RF = 0;

    // One in-flight instruction as seen by the hazard logic.
    typedef struct packed {
        logic               valid;
        logic [HZ_RD_W-1:0] rd;
        logic               reg_wr;
        logic               is_load;
    } hz_entry_t;

    // Width of a forward select able to encode FWD_RF plus one code per forwarding stage.
    function automatic int fwd_width(input int num_stages);
        return (num_stages < 1) ? 1 : $clog2(num_stages + 1);
    endfunction

endpackage

// File: rtl/hazard_shadow_pipe.sv
// rtl/hazard_shadow_pipe.sv - shift register of in-flight destination entries behind decode
module hazard_shadow_pipe
    import hazard_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  insert,
    input  hz_entry_t             ins_entry,
    output hz_entry_t [DEPTH-1:0] entries
);

    hz_entry_t [DEPTH-1:0] pipe_q;

    // Advance every entry one stage; the head takes the decode instruction or an empty slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= insert ? ins_entry : '0;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign entries = pipe_q;

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - multi-stage forwarding, load-use stall and redirect flush controller
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter  int NUM_FWD_STAGES = 2,
    parameter  int LOAD_LAT       = 1,
    parameter  int FLUSH_DEPTH    = 2,
    parameter  int REG_AW         = 5,
    localparam int FW             = fwd_width(NUM_FWD_STAGES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_wr,
    input  logic              id_is_load,
    input  logic              redirect,
    output logic              stall,
    output logic              bubble,
    output logic              flush_ifid,
    output logic [FW-1:0]     fwd_sel_1,
    output logic [FW-1:0]     fwd_sel_2
);

    localparam int CW = 3;

    hz_entry_t [NUM_FWD_STAGES-1:0] entries;
    hz_entry_t                      ins_entry;
    logic [CW-1:0]                  flush_cnt;
    logic                           flush_active;
    logic                           id_live;
    logic                           load_seen;
    logic                           load_hz;
    logic                           insert;
    logic [FW-1:0]                  sel1_raw;
    logic [FW-1:0]                  sel2_raw;

    // A shadow entry produces rs when it is a real register write to the same non-zero register.
    function automatic logic hit(input hz_entry_t e, input logic [REG_AW-1:0] rs);
        return e.valid && e.reg_wr && (e.rd == HZ_RD_W'(rs)) && (rs != '0);
    endfunction

    assign flush_active = (flush_cnt != '0);
    assign id_live      = id_valid && !flush_active && !redirect;

    // Scan oldest to youngest so the youngest hit overwrites; also look for loads still in flight.
    always_comb begin
        sel1_raw  = FW'(FWD_RF);
        sel2_raw  = FW'(FWD_RF);
        load_seen = 1'b0;
        for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
            if (hit(entries[k], id_rs1)) begin
                sel1_raw = FW'(k + 1);
            end
            if (hit(entries[k], id_rs2)) begin
                sel2_raw = FW'(k + 1);
            end
            if ((k < LOAD_LAT) && entries[k].is_load &&
                ((id_rs1_used && hit(entries[k], id_rs1)) ||
                 (id_rs2_used && hit(entries[k], id_rs2)))) begin
                load_seen = 1'b1;
            end
        end
    end

    assign load_hz    = id_live && load_seen;
    assign stall      = !rst && load_hz;
    assign bubble     = !rst && (load_hz || redirect || flush_active);
    assign flush_ifid = !rst && (redirect || flush_active);
    assign fwd_sel_1  = (!rst && id_rs1_used) ? sel1_raw : FW'(FWD_RF);
    assign fwd_sel_2  = (!rst && id_rs2_used) ? sel2_raw : FW'(FWD_RF);

    assign insert            = id_live && !bubble;
    assign ins_entry.valid   = 1'b1;
    assign ins_entry.rd      = HZ_RD_W'(id_rd);
    assign ins_entry.reg_wr  = id_reg_wr;
    assign ins_entry.is_load = id_is_load;

    // Count the remaining decode slots to kill; any redirect restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt <= '0;
        end else if (redirect) begin
            flush_cnt <= CW'(FLUSH_DEPTH - 1);
        end else if (flush_active) begin
            flush_cnt <= flush_cnt - CW'(1);
        end
    end

    hazard_shadow_pipe #(
        .DEPTH (NUM_FWD_STAGES)
    ) u_shadow_pipe (
        .clk       (clk),
        .rst       (rst),
        .insert    (insert),
        .ins_entry (ins_entry),
        .entries   (entries)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - self-checking bench for hazard_unit in two configurations
module tb_hazard_unit;

    localparam int FD = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic [4:0] id_rd;
    logic       id_reg_wr;
    logic       id_is_load;
    logic       redirect;

    logic       stall0, bubble0, flush0;
    logic [1:0] sel1_0, sel2_0;
    logic       stall1, bubble1, flush1;
    logic [1:0] sel1_1, sel2_1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit v;
        int rd;
        bit wr;
        bit ld;
    } rec_t;

    rec_t pm[2][4];
    int   flush_left = 0;

    always #5 clk = ~clk;

    hazard_unit u_dut0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_reg_wr(id_reg_wr), .id_is_load(id_is_load), .redirect(redirect),
        .stall(stall0), .bubble(bubble0), .flush_ifid(flush0),
        .fwd_sel_1(sel1_0), .fwd_sel_2(sel2_0)
    );

    hazard_unit #(.NUM_FWD_STAGES(3), .LOAD_LAT(2)) u_dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_reg_wr(id_reg_wr), .id_is_load(id_is_load), .redirect(redirect),
        .stall(stall1), .bubble(bubble1), .flush_ifid(flush1),
        .fwd_sel_1(sel1_1), .fwd_sel_2(sel2_1)
    );

    function automatic int ns_of(input int c);
        return (c == 0) ? 2 : 3;
    endfunction

    function automatic int ll_of(input int c);
        return (c == 0) ? 1 : 2;
    endfunction

    function automatic bit m_hit(input int c, input int k, input int rs);
        return pm[c][k].v && pm[c][k].wr && (pm[c][k].rd == rs) && (rs != 0);
    endfunction

    function automatic int m_sel(input int c, input int rs, input bit used);
        if (!used) return 0;
        for (int k = 0; k < ns_of(c); k++)
            if (m_hit(c, k, rs)) return k + 1;
        return 0;
    endfunction

    function automatic bit m_load(input int c, input int rs, input bit used);
        if (!used) return 0;
        for (int k = 0; k < ll_of(c); k++)
            if (m_hit(c, k, rs) && pm[c][k].ld) return 1;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int v, input int rs1, input int rs2, input int u1, input int u2,
                         input int rd, input int wr, input int ld, input int redir);
        id_valid    = v[0];
        id_rs1      = rs1[4:0];
        id_rs2      = rs2[4:0];
        id_rs1_used = u1[0];
        id_rs2_used = u2[0];
        id_rd       = rd[4:0];
        id_reg_wr   = wr[0];
        id_is_load  = ld[0];
        redirect    = redir[0];
    endtask

    // Compare both DUTs against the model at the current inputs, then clock and advance the model.
    task automatic cycle();
        bit         live;
        bit         lhz;
        int         es1, es2;
        bit         est, ebu, efl;
        logic [31:0] o_st, o_bu, o_fl, o_s1, o_s2;
        rec_t       nxt[2][4];
        live = id_valid && (flush_left == 0) && !redirect;
        for (int c = 0; c < 2; c++) begin
            lhz = live && (m_load(c, id_rs1, id_rs1_used) || m_load(c, id_rs2, id_rs2_used));
            es1 = m_sel(c, id_rs1, id_rs1_used);
            es2 = m_sel(c, id_rs2, id_rs2_used);
            est = lhz;
            ebu = lhz || redirect || (flush_left > 0);
            efl = redirect || (flush_left > 0);
            if (rst) begin
                es1 = 0; es2 = 0; est = 0; ebu = 0; efl = 0;
            end
            o_st = (c == 0) ? 32'(stall0)  : 32'(stall1);
            o_bu = (c == 0) ? 32'(bubble0) : 32'(bubble1);
            o_fl = (c == 0) ? 32'(flush0)  : 32'(flush1);
            o_s1 = (c == 0) ? 32'(sel1_0)  : 32'(sel1_1);
            o_s2 = (c == 0) ? 32'(sel2_0)  : 32'(sel2_1);
            chk($sformatf("model%0d_stall", c), o_st, 32'(est));
            chk($sformatf("model%0d_bubble", c), o_bu, 32'(ebu));
            chk($sformatf("model%0d_flush", c), o_fl, 32'(efl));
            chk($sformatf("model%0d_sel1", c), o_s1, es1);
            chk($sformatf("model%0d_sel2", c), o_s2, es2);
            for (int k = 3; k >= 1; k--) nxt[c][k] = pm[c][k-1];
            if (live && !lhz)
                nxt[c][0] = '{1'b1, int'(id_rd), id_reg_wr, id_is_load};
            else
                nxt[c][0] = '{1'b0, 0, 1'b0, 1'b0};
            if (rst)
                for (int k = 0; k < 4; k++) nxt[c][k] = '{1'b0, 0, 1'b0, 1'b0};
        end
        @(posedge clk);
        pm = nxt;
        if (rst)
            flush_left = 0;
        else if (redirect)
            flush_left = FD - 1;
        else if (flush_left > 0)
            flush_left = flush_left - 1;
        #1;
    endtask

    initial begin
        for (int c = 0; c < 2; c++)
            for (int k = 0; k < 4; k++) pm[c][k] = '{1'b0, 0, 1'b0, 1'b0};
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        // reset forces outputs low even with live-looking inputs
        drive(1, 5, 5, 1, 1, 5, 1, 1, 1); #4;
        chk("rst_stall", stall0, 0); chk("rst_bubble", bubble0, 0);
        chk("rst_flush", flush0, 0); chk("rst_sel1", sel1_0, 0);
        cycle();
        rst = 1'b0;

        // back-to-back dependency forwards from EX
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0); #4; cycle();
        drive(1, 5, 1, 1, 1, 6, 1, 0, 0); #4;
        chk("fwd_ex_sel1", sel1_0, 1); chk("fwd_ex_stall", stall0, 0); chk("fwd_ex_sel2", sel2_0, 0);
        cycle();

        // one unrelated instruction in between forwards from MEM
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0); #4; cycle();
        drive(1, 0, 0, 0, 0, 9, 1, 0, 0); #4; cycle();
        drive(1, 5, 0, 1, 0, 6, 1, 0, 0); #4;
        chk("fwd_mem_sel1", sel1_0, 2); chk("fwd_mem_sel1_c1", sel1_1, 2);
        cycle();

        // youngest producer wins
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0); #4; cycle();
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0); #4; cycle();
        drive(1, 0, 5, 0, 1, 6, 1, 0, 0); #4;
        chk("youngest_sel2", sel2_0, 1); chk("youngest_sel2_c1", sel2_1, 1);
        cycle();

        // load-use: one stall with LOAD_LAT=1, two with LOAD_LAT=2
        drive(1, 0, 0, 0, 0, 7, 1, 1, 0); #4; cycle();
        drive(1, 7, 7, 1, 1, 8, 1, 0, 0); #4;
        chk("lu_stall_c0", stall0, 1); chk("lu_bubble_c0", bubble0, 1); chk("lu_stall_c1", stall1, 1);
        cycle();
        #4;
        chk("lu_release_c0", stall0, 0); chk("lu_sel1_c0", sel1_0, 2); chk("lu_sel2_c0", sel2_0, 2);
        chk("lu_stall2_c1", stall1, 1);
        cycle();
        #4;
        chk("lu_release_c1", stall1, 0); chk("lu_sel1_c1", sel1_1, 3); chk("lu_sel2_c1", sel2_1, 3);
        cycle();

        // single redirect flushes two slots and inserts nothing
        drive(1, 0, 0, 0, 0, 10, 1, 0, 1); #4;
        chk("redir_flush", flush0, 1); chk("redir_bubble", bubble0, 1); chk("redir_stall", stall0, 0);
        cycle();
        drive(1, 0, 0, 0, 0, 11, 1, 0, 0); #4;
        chk("redir_flush2", flush0, 1); chk("redir_bubble2", bubble0, 1);
        cycle();
        drive(1, 10, 11, 1, 1, 12, 1, 0, 0); #4;
        chk("redir_done", flush0, 0); chk("redir_done_bub", bubble0, 0);
        chk("redir_noins1", sel1_0, 0); chk("redir_noins2", sel2_0, 0);
        cycle();

        // redirect during a flush extends it to three cycles
        drive(1, 0, 0, 0, 0, 13, 1, 0, 1); #4; chk("dbl_f1", flush0, 1); cycle();
        drive(1, 0, 0, 0, 0, 13, 1, 0, 1); #4; chk("dbl_f2", flush0, 1); cycle();
        drive(1, 0, 0, 0, 0, 14, 1, 0, 0); #4; chk("dbl_f3", flush0, 1); cycle();
        drive(1, 0, 0, 0, 0, 15, 1, 0, 0); #4; chk("dbl_f4", flush0, 0); cycle();

        // redirect overrides a load-use stall
        drive(1, 0, 0, 0, 0, 7, 1, 1, 0); #4; cycle();
        drive(1, 7, 0, 1, 0, 8, 1, 0, 1); #4;
        chk("redir_lu_stall", stall0, 0); chk("redir_lu_bubble", bubble0, 1); chk("redir_lu_flush", flush0, 1);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #4; cycle();

        // x0 neither forwards nor stalls
        drive(1, 0, 0, 0, 0, 0, 1, 1, 0); #4; cycle();
        drive(1, 0, 0, 1, 1, 9, 1, 0, 0); #4;
        chk("x0_sel1", sel1_0, 0); chk("x0_sel2", sel2_0, 0); chk("x0_stall", stall0, 0);
        cycle();

        // unused operands neither forward nor stall
        drive(1, 0, 0, 0, 0, 7, 1, 1, 0); #4; cycle();
        drive(1, 7, 7, 0, 0, 9, 1, 0, 0); #4;
        chk("unused_sel1", sel1_0, 0); chk("unused_sel2", sel2_0, 0); chk("unused_stall", stall0, 0);
        cycle();

        // reset in the middle of a stall
        drive(1, 0, 0, 0, 0, 7, 1, 1, 0); #4; cycle();
        drive(1, 7, 0, 1, 0, 8, 1, 0, 0); #4; chk("ms_stall", stall0, 1); cycle();
        rst = 1'b1; #4;
        chk("ms_rst_stall", stall0, 0); chk("ms_rst_bubble", bubble0, 0); chk("ms_rst_sel1", sel1_0, 0);
        cycle();
        rst = 1'b0; #4;
        chk("ms_after_stall", stall0, 0); chk("ms_after_sel1", sel1_0, 0);
        cycle();

        // reset in the middle of a flush
        drive(1, 0, 0, 0, 0, 3, 1, 0, 1); #4; cycle();
        rst = 1'b1; drive(1, 0, 0, 0, 0, 4, 1, 0, 0); #4;
        chk("mf_rst_flush", flush0, 0); chk("mf_rst_bubble", bubble0, 0);
        cycle();
        rst = 1'b0; #4;
        chk("mf_after_flush", flush0, 0); chk("mf_after_bubble", bubble0, 0);
        cycle();

        // randomized traffic over a small register set to provoke hits
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive(($urandom_range(0, 9) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 11) == 0));
            #4;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
